merge_fifo_ms: RTL and testbench
================================

MERGE_FIFO_MS -- requirements
Module: merge_fifo_ms

Interface
REQ-001 SHALL have parameter WIDTH, default 8: output word width, tag included.
REQ-002 SHALL have parameter DEPTH, default 4: entries per flux queue; power of 2, >=2.
REQ-003 SHALL have parameter FLUX, default 2: number of input fluxes, >=2.
REQ-004 SHALL derive TAG_WIDTH = clog2(FLUX) and PAYLOAD = WIDTH-TAG_WIDTH.
REQ-005 SHALL have port ck  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port wr  input  FLUX  per-flux write strobe.
REQ-008 SHALL have port datain  input  FLUX*PAYLOAD  packed payloads; flux i occupies bits [i*PAYLOAD +: PAYLOAD].
REQ-009 SHALL have port rd  input  1  pop request for the merged stream.
REQ-010 SHALL have port full  output  FLUX  per-flux queue full flag.
REQ-011 SHALL have port empty  output  1  high when all flux queues are empty.
REQ-012 SHALL have port dataout  output  WIDTH  registered merged word, {tag, payload}; tag in MSBs [WIDTH-1 -: TAG_WIDTH].

Function
REQ-013 SHALL keep one circular queue per flux, with write pointer, read pointer and occupancy count 0..DEPTH.
REQ-014 SHALL drive full[i]=1 exactly when count[i]==DEPTH, combinationally from registered state.
REQ-015 SHALL drive empty=1 exactly when every count[i]==0.
REQ-016 SHALL store datain slice i at wp[i] and increment wp[i] modulo DEPTH on an edge where wr[i]=1 and full[i]=0.
REQ-017 SHALL drop a write with wr[i]=1 and full[i]=1 silently; state unchanged, even if the same edge pops flux i.
REQ-018 SHALL treat all FLUX writes as independent; simultaneous writes to different fluxes all succeed when not full.
REQ-019 SHALL perform a pop on an edge where rd=1 and empty=0; rd=1 with empty=1 is ignored and dataout holds.
REQ-020 SHALL pick the popped flux by round-robin among non-empty queues: search ascending from (last+1) mod FLUX, wrapping.
REQ-021 SHALL update last to the granted flux on each pop only.
REQ-022 SHALL load dataout with {granted flux index, entry at rp[g]} on the pop edge, visible the following cycle (1-cycle latency), and increment rp[g] modulo DEPTH.
REQ-023 SHALL hold dataout between pops.
REQ-024 SHALL, on one edge with write and pop to the same flux, apply both: count unchanged, pointers both advance.
REQ-025 SHALL not make a flux that is empty before the edge eligible for a pop on that edge; no write-through.
REQ-026 SHALL keep count[i] in [0,DEPTH] at all times; pointer wrap from DEPTH-1 to 0 needs no special case.
REQ-027 SHALL produce output words usable directly as tagged input of the team's demultiplexing FIFO with the same WIDTH/FLUX.

Reset
REQ-028 SHALL, on rst=1 and regardless of ck, clear all pointers and counts, set last=FLUX-1, set dataout=0.
REQ-029 SHALL have full=0, empty=1 while in reset and after it.
REQ-030 SHALL, on reset asserted mid-operation, discard all queued data; storage contents need not be cleared.

Verification (WIDTH=8, DEPTH=4, FLUX=2, PAYLOAD=7)
REQ-031 SHALL cover: reset pulse -> full=2'b00, empty=1, dataout=8'h00; rd=1 for 3 cycles -> dataout stays 8'h00.
REQ-032 SHALL cover: wr=2'b01, payload0=7'h15, then rd=1 -> next cycle dataout=8'h15, empty=1.
REQ-033 SHALL cover: wr=2'b10, payload1=7'h05, then rd -> dataout=8'h85 (tag 1).
REQ-034 SHALL cover: 5 writes to flux0 (7'h01..7'h05) -> full=2'b01 after 4th, 5th dropped; 4 pops -> 8'h01..8'h04, then empty=1.
REQ-035 SHALL cover: flux0 holds 7'h0A,7'h0B; flux1 holds 7'h1A,7'h1B; 4 consecutive rd -> 8'h0A, 8'h9A, 8'h0B, 8'h9B.
REQ-036 SHALL cover: flux0 full, same-edge wr[0]=1 and rd=1 -> write dropped, count 3, full[0]=0; then rst mid-burst -> empty=1, dataout=8'h00, next pop waits for new write.

Source files
------------

// File: rtl/merge_fifo_ms.sv
// merge_fifo_ms: FLUX independent circular queues merged into one tagged output stream.
// Each popped word is {flux index, payload}. The source flux is chosen round-robin,
// starting the search after the flux that was granted last.
module merge_fifo_ms #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FLUX  = 2,
    localparam int unsigned TAG_WIDTH = $clog2(FLUX),
    localparam int unsigned PAYLOAD   = WIDTH - TAG_WIDTH
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic [FLUX-1:0]           wr,
    input  logic [FLUX*PAYLOAD-1:0]   datain,
    input  logic                      rd,
    output logic [FLUX-1:0]           full,
    output logic                      empty,
    output logic [WIDTH-1:0]          dataout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PAYLOAD-1:0]   mem_q [FLUX][DEPTH];
    logic [AW-1:0]        wp_q  [FLUX];
    logic [AW-1:0]        wp_d  [FLUX];
    logic [AW-1:0]        rp_q  [FLUX];
    logic [AW-1:0]        rp_d  [FLUX];
    logic [CW-1:0]        cnt_q [FLUX];
    logic [CW-1:0]        cnt_d [FLUX];
    logic [TAG_WIDTH-1:0] last_q, last_d;
    logic [TAG_WIDTH-1:0] gnt;
    logic                 found;
    logic [WIDTH-1:0]     dataout_q, dataout_d;
    logic [FLUX-1:0]      nonempty;
    logic [FLUX-1:0]      wr_ok;
    logic [FLUX-1:0]      pop_sel;
    logic                 pop;

    // Status flags, derived only from registered counts.
    always_comb begin
        for (int i = 0; i < int'(FLUX); i++) begin
            full[i]     = (cnt_q[i] == CW'(DEPTH));
            nonempty[i] = (cnt_q[i] != '0);
        end
    end

    assign empty = ~|nonempty;
    assign pop   = rd & ~empty;

    // Round-robin grant: first non-empty flux above last, else first at or below it.
    always_comb begin
        gnt   = last_q;
        found = 1'b0;
        for (int i = 0; i < int'(FLUX); i++) begin
            if (!found && nonempty[i] && (i > int'(last_q))) begin
                gnt   = TAG_WIDTH'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < int'(FLUX); i++) begin
            if (!found && nonempty[i] && (i <= int'(last_q))) begin
                gnt   = TAG_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

    // Next-state for pointers, counts, arbitration history and the output register.
    // A write to a full queue is dropped even if that queue is popped on the same edge.
    always_comb begin
        last_d    = last_q;
        dataout_d = dataout_q;
        for (int i = 0; i < int'(FLUX); i++) begin
            wr_ok[i]   = wr[i] & ~full[i];
            pop_sel[i] = pop && (gnt == TAG_WIDTH'(i));
            wp_d[i]    = wr_ok[i]   ? wp_q[i] + 1'b1 : wp_q[i];
            rp_d[i]    = pop_sel[i] ? rp_q[i] + 1'b1 : rp_q[i];
            unique case ({wr_ok[i], pop_sel[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        if (pop) begin
            last_d    = gnt;
            dataout_d = {gnt, mem_q[gnt][rp_q[gnt]]};
        end
    end

    // Control state with asynchronous reset; queued data is discarded by clearing counts.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FLUX); i++) begin
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            last_q    <= TAG_WIDTH'(FLUX - 1);
            dataout_q <= '0;
        end else begin
            for (int i = 0; i < int'(FLUX); i++) begin
                wp_q[i]  <= wp_d[i];
                rp_q[i]  <= rp_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            last_q    <= last_d;
            dataout_q <= dataout_d;
        end
    end

    // Queue storage; no reset needed since counts gate every read.
    always_ff @(posedge ck) begin
        for (int i = 0; i < int'(FLUX); i++) begin
            if (wr_ok[i]) begin
                mem_q[i][wp_q[i]] <= datain[i*PAYLOAD +: PAYLOAD];
            end
        end
    end

    assign dataout = dataout_q;

endmodule

// File: tb/tb_merge_fifo_ms.sv
// Directed self-checking bench for merge_fifo_ms (WIDTH=8, DEPTH=4, FLUX=2).
module tb_merge_fifo_ms;

    logic        ck = 1'b0;
    logic        rst;
    logic [1:0]  wr;
    logic [13:0] datain;
    logic        rd;
    logic [1:0]  full;
    logic        empty;
    logic [7:0]  dataout;

    int n_cmp = 0;
    int n_bad = 0;

    merge_fifo_ms #(
        .WIDTH (8),
        .DEPTH (4),
        .FLUX  (2)
    ) dut (
        .ck      (ck),
        .rst     (rst),
        .wr      (wr),
        .datain  (datain),
        .rd      (rd),
        .full    (full),
        .empty   (empty),
        .dataout (dataout)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr  = 2'b00;
        rd  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 2'b00; rd = 1'b0; datain = '0;
        tick();
        n_cmp++; if (full !== 2'b00) begin n_bad++; $display("FAIL rst_full: got %b want 00", full); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_cmp++; if (dataout !== 8'h00) begin n_bad++; $display("FAIL rst_dout: got %h want 00", dataout); end
        rst = 1'b0;
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL post_rst_empty: got %b want 1", empty); end
        rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (dataout !== 8'h00) begin
                n_bad++; $display("FAIL rd_on_empty[%0d]: got %h want 00", k, dataout);
            end
        end
        rd = 1'b0;
    endtask

    task automatic test_flux0();
        wr = 2'b01; datain = {7'h00, 7'h15};
        tick();
        wr = 2'b00;
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL f0_empty_after_wr: got %b want 0", empty); end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_cmp++; if (dataout !== 8'h15) begin n_bad++; $display("FAIL f0_dout: got %h want 15", dataout); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL f0_empty: got %b want 1", empty); end
    endtask

    task automatic test_flux1();
        wr = 2'b10; datain = {7'h05, 7'h00};
        tick();
        wr = 2'b00; rd = 1'b1;
        tick();
        rd = 1'b0;
        n_cmp++; if (dataout !== 8'h85) begin n_bad++; $display("FAIL f1_dout: got %h want 85", dataout); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL f1_empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        logic [1:0] exp_full;
        logic [7:0] exp_dout;
        for (int k = 1; k <= 5; k++) begin
            wr = 2'b01; datain = {7'h00, 7'(k)};
            tick();
            exp_full = (k >= 4) ? 2'b01 : 2'b00;
            n_cmp++;
            if (full !== exp_full) begin
                n_bad++; $display("FAIL full_after_wr%0d: got %b want %b", k, full, exp_full);
            end
        end
        wr = 2'b00; rd = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_dout = {1'b0, 7'(k)};
            n_cmp++;
            if (dataout !== exp_dout) begin
                n_bad++; $display("FAIL full_pop%0d: got %h want %h", k, dataout, exp_dout);
            end
        end
        rd = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL full_drain_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 2'b00) begin n_bad++; $display("FAIL full_drain_full: got %b want 00", full); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [4];
        exp = '{8'h0A, 8'h9A, 8'h0B, 8'h9B};
        do_reset();
        wr = 2'b11; datain = {7'h1A, 7'h0A};
        tick();
        datain = {7'h1B, 7'h0B};
        tick();
        wr = 2'b00; rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (dataout !== exp[k]) begin
                n_bad++; $display("FAIL rr_pop%0d: got %h want %h", k, dataout, exp[k]);
            end
        end
        rd = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rr_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_pop_and_mid_reset();
        logic [7:0] exp [3];
        exp = '{8'h22, 8'h23, 8'h24};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wr = 2'b01; datain = {7'h00, 7'(8'h21 + k)};
            tick();
        end
        n_cmp++; if (full !== 2'b01) begin n_bad++; $display("FAIL sp_full: got %b want 01", full); end
        // write to full flux0 on the same edge as a pop of flux0: write is dropped
        wr = 2'b01; datain = {7'h00, 7'h55}; rd = 1'b1;
        tick();
        wr = 2'b00;
        n_cmp++; if (dataout !== 8'h21) begin n_bad++; $display("FAIL sp_dout: got %h want 21", dataout); end
        n_cmp++; if (full !== 2'b00) begin n_bad++; $display("FAIL sp_full_after: got %b want 00", full); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (dataout !== exp[k]) begin
                n_bad++; $display("FAIL sp_drain%0d: got %h want %h", k, dataout, exp[k]);
            end
        end
        rd = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL sp_drop_empty: got %b want 1", empty); end

        // reset asserted between edges with data still queued
        wr = 2'b01; datain = {7'h00, 7'h41};
        tick();
        datain = {7'h00, 7'h42};
        tick();
        wr = 2'b00; rd = 1'b1;
        tick();
        n_cmp++; if (dataout !== 8'h41) begin n_bad++; $display("FAIL mr_pre_dout: got %h want 41", dataout); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mr_empty: got %b want 1", empty); end
        n_cmp++; if (dataout !== 8'h00) begin n_bad++; $display("FAIL mr_dout: got %h want 00", dataout); end
        n_cmp++; if (full !== 2'b00) begin n_bad++; $display("FAIL mr_full: got %b want 00", full); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (dataout !== 8'h00) begin n_bad++; $display("FAIL mr_no_stale: got %h want 00", dataout); end
        // write and rd on the same edge to an empty flux: no write-through
        wr = 2'b10; datain = {7'h33, 7'h00};
        tick();
        wr = 2'b00;
        n_cmp++; if (dataout !== 8'h00) begin n_bad++; $display("FAIL mr_no_wthru: got %h want 00", dataout); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL mr_new_empty: got %b want 0", empty); end
        tick();
        rd = 1'b0;
        n_cmp++; if (dataout !== 8'hB3) begin n_bad++; $display("FAIL mr_new_dout: got %h want b3", dataout); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mr_final_empty: got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr = 2'b01; datain = {7'h00, 7'h11};
        tick();
        // push and pop flux0 together: occupancy stays at one
        datain = {7'h00, 7'h12}; rd = 1'b1;
        tick();
        wr = 2'b00;
        n_cmp++; if (dataout !== 8'h11) begin n_bad++; $display("FAIL b2b_dout0: got %h want 11", dataout); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL b2b_empty0: got %b want 0", empty); end
        tick();
        n_cmp++; if (dataout !== 8'h12) begin n_bad++; $display("FAIL b2b_dout1: got %h want 12", dataout); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b_empty1: got %b want 1", empty); end
        tick();
        rd = 1'b0;
        tick();
        n_cmp++; if (dataout !== 8'h12) begin n_bad++; $display("FAIL b2b_hold: got %h want 12", dataout); end
    endtask

    initial begin
        test_reset();
        test_flux0();
        test_flux1();
        test_full();
        test_round_robin();
        test_full_pop_and_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
